mux_rr_reg: RTL and testbench
=============================

Name: mux_rr_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the 4:1 single-bit combinational mux in the ALU datapath.
- Adds per-channel valid/ready handshake and one output pipeline register.
- Two select modes: fixed (external select, like the old s1/s0) and round-robin arbitration across valid channels.
- Sits between ALU operand sources and the ALU input/result bus.

Parameters:
- WIDTH, 4, data width per channel.
- CHANNELS, 4, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), select/channel-index width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; transfer on in_valid[i] && in_ready[i].
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the source channel.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer ptr=CHANNELS-1, so channel 0 has first priority.
  - Reset mid-transfer discards the held word. in_ready is all-zero while rst=1.
- load_en = !out_valid || out_ready. This gives full throughput: one word per cycle with out_ready held high.
- Grant (combinational, at most one-hot):
  - Fixed mode: grant channel sel iff in_valid[sel]. If sel >= CHANNELS, no grant.
  - RR mode: grant the first valid channel searching ptr+1, ptr+2, ... with wrap modulo CHANNELS. No valid channel means no grant.
- in_ready[i] = load_en && grant==i && !rst. Non-granted channels see in_ready=0 and must hold their data.
- On a clk edge with load_en:
  - If there is a grant: out_data <= granted data, out_chan <= granted index, out_valid <= 1.
  - If there is no grant: out_valid <= 0. out_data and out_chan hold their previous values.
- When !load_en, all output registers hold. Stall: out_valid=1 && !out_ready means all in_ready=0.
- ptr updates to the granted index only on an actual RR-mode transfer. Fixed-mode transfers do not move ptr.
- Latency: an input accepted at edge k appears on out_* after edge k (one cycle).
- Mode or sel changes take effect on the grant in the same cycle. Nothing is latched, and ptr is retained across mode switches.
- Simultaneous events:
  - Output drain and new load on the same edge is a normal transfer, with no bubble.
  - In RR mode, with all channels valid every cycle, grants rotate 0,1,2,3,0,...
- The last RR-granted channel has lowest priority next cycle; no channel starves while out_ready keeps toggling.

Decomposition:
- Package mux_pkg: MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req[CHANNELS], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Uses a double-width rotate/priority scheme.
- Top level holds ptr, the output register, the fixed-mode path and handshake logic.

Test Plan:
- Reset/idle: assert rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0. After release with in_valid=0 -> out_valid stays 0.
- Fixed select sweep, out_ready=1:
  - Setup: mode=0, in_data ch0..3 = 4'h1,4'h2,4'h4,4'h8, all valid.
  - sel=0,1,2,3 on consecutive cycles -> out_data 1,2,4,8 and out_chan 0..3 one cycle later. in_ready is one-hot matching sel.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_chan 0,1,2,3,0,1,2,3. With only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure:
  - out_valid=1 with out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0000, ptr unchanged.
  - Releasing out_ready -> next channel in RR order loads on the same edge the held word drains.
- Edge conditions:
  - Fixed mode with sel=2, in_valid=1011 -> no grant, out_valid drops to 0 after next edge.
  - Switch to mode=1 -> grant continues from the retained ptr.
  - Assert rst while out_valid=1 -> out_valid=0 after the edge, and ch0 is granted first after release.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared select-mode encodings for the registered channel mux.
// Revision    : 1.0
// ============================================================================
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter, search starts after ptr.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    logic [2*CHANNELS-1:0] w_dbl;

    // Doubling the request vector lets a linear scan from ptr+1 cover the wrap.
    assign w_dbl = {req, req};

    always_comb begin
        int w_start;
        int w_idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        w_start   = (int'(ptr) >= CHANNELS - 1) ? 0 : int'(ptr) + 1;
        // Descending scan: the closest requester after ptr is written last.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_dbl[w_start + k]) begin
                gnt_valid = 1'b1;
                w_idx     = w_start + k;
                if (w_idx >= CHANNELS) begin
                    w_idx = w_idx - CHANNELS;
                end
                gnt_idx   = SEL_W'(w_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_reg
// Description : N-channel registered mux, fixed or round-robin select, valid/ready.
// Revision    : 1.0
// ============================================================================
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic             w_load_en;
    logic             w_fix_valid;
    logic             w_arb_valid;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;

    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            assign w_ch[i]     = in_data[i*WIDTH +: WIDTH];
            assign in_ready[i] = w_load_en && w_gnt_valid &&
                                 (w_gnt_idx == SEL_W'(i)) && !rst;
        end
    endgenerate

    assign w_load_en = !out_valid_q || out_ready;

    // Out-of-range select values must never produce a grant.
    always_comb begin
        w_fix_valid = 1'b0;
        if (int'(sel) < CHANNELS) begin
            w_fix_valid = in_valid[sel];
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (w_arb_valid),
        .gnt_idx   (w_arb_idx)
    );

    assign w_gnt_valid = (mode == MODE_RR) ? w_arb_valid : w_fix_valid;
    assign w_gnt_idx   = (mode == MODE_RR) ? w_arb_idx   : sel;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (w_load_en) begin
            if (w_gnt_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = w_ch[w_gnt_idx];
                out_chan_d  = w_gnt_idx;
                // Only round-robin transfers move the fairness pointer.
                if (mode == MODE_RR) begin
                    ptr_d = w_gnt_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= SEL_W'(CHANNELS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule : mux_rr_reg
`default_nettype wire

// File: tb/tb_mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_reg
// Description : Self-checking bench for mux_rr_reg against a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_mux_rr_reg;
    localparam int W  = 4;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_ptr   = CH - 1;

    mux_rr_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant from the rules: fixed picks sel if valid; RR scans ptr+1.. modulo CH.
    function automatic void model_grant(output logic g, output int gi);
        g  = 1'b0;
        gi = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < CH && in_valid[sel]) begin
                g  = 1'b1;
                gi = int'(sel);
            end
        end else begin
            for (int off = 1; off <= CH; off++) begin
                if (!g && in_valid[(m_ptr + off) % CH]) begin
                    g  = 1'b1;
                    gi = (m_ptr + off) % CH;
                end
            end
        end
    endfunction

    // One clock: check in_ready, advance model on the edge, check outputs.
    task automatic step();
        logic          g;
        int            gi;
        logic          le;
        logic [CH-1:0] er;
        #1;
        model_grant(g, gi);
        le = !m_valid || out_ready;
        er = '0;
        if (le && g && !rst) er[gi] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_ptr   = CH - 1;
        end else if (le) begin
            if (g) begin
                m_valid = 1'b1;
                m_data  = in_data[gi*W +: W];
                m_chan  = gi;
                if (mode) m_ptr = gi;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_chan",  32'(out_chan),  32'(m_chan));
        @(negedge clk);
    endtask

    initial begin
        int rr_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int rr_13  [4] = '{1, 3, 1, 3};
        logic [W-1:0] fx [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

        rst = 1'b1; in_valid = '1; in_data = 16'h8421;
        mode = 1'b0; sel = '0; out_ready = 1'b1;
        @(negedge clk);

        // Reset with all channels requesting
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
        rst = 1'b0; in_valid = '0;
        step(); step();
        check("idle_out_valid", 32'(out_valid), 32'h0);

        // Fixed select sweep
        in_valid = '1;
        for (int k = 0; k < 4; k++) begin
            sel = SW'(k);
            step();
            check("fix_data", 32'(out_data), 32'(fx[k]));
            check("fix_chan", 32'(out_chan), 32'(k));
        end

        // Round-robin fairness
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_all_chan", 32'(out_chan), 32'(rr_all[k]));
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_13_chan", 32'(out_chan), 32'(rr_13[k]));
        end

        // Backpressure: ch3 held, then ch0 loads as it drains
        in_valid = '1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_chan", 32'(out_chan), 32'h3);
            check("stall_data", 32'(out_data), 32'h8);
            check("stall_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        step();
        check("release_chan", 32'(out_chan), 32'h0);
        check("release_valid", 32'(out_valid), 32'h1);

        // Fixed sel=2 with ch2 idle: bubble
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
        step();
        check("nogrant_valid", 32'(out_valid), 32'h0);
        // Back to RR: ptr retained at 0, so ch1 is next
        mode = 1'b1; in_valid = '1;
        step();
        check("resume_chan", 32'(out_chan), 32'h1);
        // Reset mid-stream, then ch0 wins first
        rst = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        step();
        check("postrst_chan", 32'(out_chan), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = CH'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule : tb_mux_rr_reg
`default_nettype wire
